// File: rtl/exhaustive_stim_gen_pkg.sv
// Shared definitions for the exhaustive stimulus generator: FSM states and MISR defaults.
package exhaustive_stim_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [15:0] DEF_SIG_POLY = 16'h1021;
    localparam logic [15:0] DEF_SIG_SEED = 16'hFFFF;

endpackage

// File: rtl/exhaustive_stim_gen_if.sv
// Bus between the sweep generator (master) and the bench/DUT side (slave).
interface exhaustive_stim_gen_if #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned N_OUT = 1,
    parameter int unsigned SIG_W = 16
);
    logic             start;
    logic             abort;
    logic [N_OUT-1:0] dut_out;
    logic [N_IN-1:0]  stim;
    logic [N_IN-1:0]  vec_idx;
    logic             sample;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;

    modport master (
        input  start, abort, dut_out,
        output stim, vec_idx, sample, busy, done, signature
    );

    modport slave (
        output start, abort, dut_out,
        input  stim, vec_idx, sample, busy, done, signature
    );
endinterface

// File: rtl/exhaustive_stim_gen_misr.sv
// misr_reg: multiple-input signature register folding N_OUT response bits per shift.
module misr_reg
    import exhaustive_stim_gen_pkg::*;
#(
    parameter int unsigned      SIG_W    = 16,
    parameter int unsigned      N_OUT    = 1,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEF_SIG_POLY),
    parameter logic [SIG_W-1:0] SIG_SEED = SIG_W'(DEF_SIG_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [N_OUT-1:0] din,
    output logic [SIG_W-1:0] sig
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= SIG_SEED;
        end else if (load) begin
            sig <= SIG_SEED;
        end else if (shift) begin
            sig <= {sig[SIG_W-2:0], 1'b0}
                 ^ (sig[SIG_W-1] ? SIG_POLY : '0)
                 ^ SIG_W'(din);
        end
    end

endmodule

// File: rtl/exhaustive_stim_gen.sv
// Truth-table sweeper: drives 0..2^N_IN-1, holds each HOLD_CYCLES clocks, strobes sample.
// Macro SIGNATURE_EN enables the MISR signature; otherwise signature is constant 0.
module exhaustive_stim_gen
    import exhaustive_stim_gen_pkg::*;
#(
    parameter int unsigned      N_IN        = 3,
    parameter int unsigned      N_OUT       = 1,
    parameter int unsigned      HOLD_CYCLES = 10,
    parameter int unsigned      SIG_W       = 16,
    parameter logic [SIG_W-1:0] SIG_POLY    = SIG_W'(DEF_SIG_POLY),
    parameter logic [SIG_W-1:0] SIG_SEED    = SIG_W'(DEF_SIG_SEED)
) (
    input logic                  clk,
    input logic                  rst,
    exhaustive_stim_gen_if.master bus
);

    localparam int unsigned      IDX_W    = N_IN + 1;
    localparam int unsigned      CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << N_IN) - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             misr_load, misr_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = idx;
        busy_n     = busy_q;
        done_n     = done_q;
        misr_load  = 1'b0;
        misr_shift = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_n   = ST_HOLD;
                    busy_n    = 1'b1;
                    done_n    = 1'b0;
                    idx_n     = '0;
                    cnt_n     = '0;
                    misr_load = 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.abort) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                    idx_n   = '0;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = ST_SAMPLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                // An abort on the sampling clock cancels the sweep before the fold.
                if (bus.abort) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                    idx_n   = '0;
                    cnt_n   = '0;
                end else begin
                    misr_shift = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_n = ST_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ST_HOLD;
                        idx_n   = idx + IDX_W'(1);
                        cnt_n   = '0;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.stim    = idx[N_IN-1:0];
    assign bus.vec_idx = idx[N_IN-1:0];
    assign bus.sample  = (state == ST_SAMPLE);
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

`ifdef SIGNATURE_EN
    logic [SIG_W-1:0] sig;

    misr_reg #(
        .SIG_W   (SIG_W),
        .N_OUT   (N_OUT),
        .SIG_POLY(SIG_POLY),
        .SIG_SEED(SIG_SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (misr_load),
        .shift(misr_shift),
        .din  (bus.dut_out),
        .sig  (sig)
    );

    assign bus.signature = sig;
`else
    logic unused_misr;
    assign unused_misr   = ^{misr_load, misr_shift, bus.dut_out, SIG_POLY, SIG_SEED};
    assign bus.signature = '0;
`endif

endmodule

// File: tb/tb_exhaustive_stim_gen.sv
// Bench for exhaustive_stim_gen: 3-input majority DUT plus a 1-input, HOLD_CYCLES=1 instance.
module tb_exhaustive_stim_gen;

    localparam int HC  = 2;
    localparam int PER = HC + 1;
    localparam int NV  = 8;
    localparam logic [7:0] MAJ = 8'hE8;  // majority(A,B,C) for vectors 0..7

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exhaustive_stim_gen_if #(.N_IN(3), .N_OUT(1), .SIG_W(16)) bus ();
    exhaustive_stim_gen_if #(.N_IN(1), .N_OUT(1), .SIG_W(16)) bus2 ();

    exhaustive_stim_gen #(
        .N_IN(3), .N_OUT(1), .HOLD_CYCLES(HC), .SIG_W(16),
        .SIG_POLY(16'h1021), .SIG_SEED(16'hFFFF)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    exhaustive_stim_gen #(
        .N_IN(1), .N_OUT(1), .HOLD_CYCLES(1), .SIG_W(16),
        .SIG_POLY(16'h1021), .SIG_SEED(16'hFFFF)
    ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic [7:0] ztab;
    assign bus.dut_out  = ztab[bus.stim];
    assign bus2.dut_out = bus2.stim;

    int checks = 0;
    int errors = 0;

    // Signature after folding the first n response bits, computed arithmetically.
    function automatic logic [15:0] misr_model(input logic [7:0] zs, input int n);
        int unsigned s;
        s = 32'hFFFF;
        for (int i = 0; i < n; i++) begin
            s = s * 2;
            if (s >= 32'h10000) s = (s - 32'h10000) ^ 32'h1021;
            s = s ^ 32'(zs[i]);
        end
        return s[15:0];
    endfunction

    function automatic logic [15:0] exp_sig(input logic [7:0] zs, input int n);
`ifdef SIGNATURE_EN
        return misr_model(zs, n);
`else
        return 16'h0000 & {8'h00, zs} & 16'(n);
`endif
    endfunction

    function automatic logic [15:0] reset_sig();
`ifdef SIGNATURE_EN
        return 16'hFFFF;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [2:0] s, input logic [2:0] v,
                                         input logic smp, input logic b, input logic d);
        return {23'd0, s, v, smp, b, d};
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, pack(bus.stim, bus.vec_idx, bus.sample, bus.busy, bus.done), 32'd0);
        chk({tag, "_sig"}, 32'(bus.signature), 32'(reset_sig()));
    endtask

    // One sweep from a start pulse. cut_at>=0 cancels after that clock: kind 0 abort, 1 rst.
    task automatic run_sweep(input string tag, input logic [7:0] zs, input bit spurious,
                             input bit abort_with_start, input int cut_at, input int cut_kind);
        int v;
        ztab = zs;
        bus.start = 1'b1;
        bus.abort = abort_with_start;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int k = 0; k <= NV * PER; k++) begin
            v = k / PER;
            if (k < NV * PER) begin
                chk({tag, "_ctl"}, pack(bus.stim, bus.vec_idx, bus.sample, bus.busy, bus.done),
                    pack(3'(v), 3'(v), (k % PER) == HC, 1'b1, 1'b0));
                chk({tag, "_sig"}, 32'(bus.signature), 32'(exp_sig(zs, v)));
            end else begin
                chk({tag, "_end"}, pack(bus.stim, bus.vec_idx, bus.sample, bus.busy, bus.done),
                    pack(3'd7, 3'd7, 1'b0, 1'b0, 1'b1));
                chk({tag, "_endsig"}, 32'(bus.signature), 32'(exp_sig(zs, NV)));
            end
            if (k == cut_at && cut_kind == 0) begin
                bus.abort = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
                chk({tag, "_abort"}, pack(bus.stim, bus.vec_idx, bus.sample, bus.busy, bus.done),
                    32'd0);
                chk({tag, "_abortsig"}, 32'(bus.signature), 32'(exp_sig(zs, v)));
                break;
            end
            if (k == cut_at && cut_kind == 1) begin
                #1 rst = 1'b1;
                #1 chk_reset({tag, "_rst"});
                @(negedge clk);
                rst = 1'b0;
                chk_reset({tag, "_rsthold"});
                break;
            end
            if (k < NV * PER) begin
                bus.start = spurious && (($urandom_range(0, 3) == 0) || (v == 4 && (k % PER) == 0));
                @(negedge clk);
                bus.start = 1'b0;
            end
        end
    endtask

    logic [7:0] rtab;
    int         kab;

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus2.start = 1'b0;
        bus2.abort = 1'b0;
        ztab       = MAJ;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        chk("reset2", {29'd0, bus2.sample, bus2.busy, bus2.done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_sweep("sweep_maj", MAJ, 1'b0, 1'b0, -1, 0);

        // abort and start while not busy: abort is ignored, done/signature stay put
        bus.abort = 1'b1;
        repeat (3) @(negedge clk);
        bus.abort = 1'b0;
        chk("idle_abort", pack(bus.stim, bus.vec_idx, bus.sample, bus.busy, bus.done),
            pack(3'd7, 3'd7, 1'b0, 1'b0, 1'b1));
        chk("idle_abort_sig", 32'(bus.signature), 32'(exp_sig(MAJ, NV)));

        run_sweep("sweep_zero", 8'h00, 1'b0, 1'b1, -1, 0);
`ifdef SIGNATURE_EN
        chk("sig_differs", 32'(bus.signature != misr_model(MAJ, NV)), 32'd1);
`endif

        run_sweep("sweep_spur", MAJ, 1'b1, 1'b0, -1, 0);

        rtab = 8'($urandom());
        run_sweep("sweep_rand", rtab, 1'b1, 1'b0, -1, 0);

        kab = 5 * PER + $urandom_range(0, HC - 1);
        run_sweep("abort_v5", MAJ, 1'b0, 1'b0, kab, 0);
        run_sweep("after_abort", MAJ, 1'b0, 1'b0, -1, 0);

        kab = $urandom_range(0, NV - 1) * PER + $urandom_range(0, HC - 1);
        run_sweep("abort_rand", rtab, 1'b1, 1'b0, kab, 0);

        kab = $urandom_range(0, NV - 1) * PER + HC;
        run_sweep("rst_sample", MAJ, 1'b0, 1'b0, kab, 1);
        run_sweep("after_rst", MAJ, 1'b0, 1'b0, -1, 0);

        // 1-input instance: per-vector period 2, done four clocks after start
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            if (k < 4)
                chk("small_ctl", {29'd0, bus2.stim, bus2.sample, bus2.busy, bus2.done},
                    {29'd0, 1'(k / 2), 1'((k % 2) == 1), 1'b1, 1'b0});
            else
                chk("small_end", {29'd0, bus2.stim, bus2.sample, bus2.busy, bus2.done},
                    {29'd0, 1'b1, 1'b0, 1'b0, 1'b1});
            if (k < 4) @(negedge clk);
        end
        chk("small_sig", 32'(bus2.signature), 32'(exp_sig(8'b10, 2)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
